// File: rtl/mxint8_block_assembler_pkg.sv
// Types and helpers local to the MXINT8 block assembler.
package mxint8_block_assembler_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FILL  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int BLOCK_BITS = mxint8_includes::BLOCK_SIZE * mxint8_includes::MXINT8_ELEMENT_WIDTH;

  // A beat is mis-framed when i_last disagrees with the beat position.
  function automatic logic frame_error(input logic last, input logic at_final);
    return last ^ at_final;
  endfunction

endpackage

// File: rtl/mxint8_includes.sv
// Shared MXINT8 format constants (block geometry, element and scale widths)
// used by every stage of the MX datapath.
package mxint8_includes;

  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int BLOCK_SIZE = 32;
  localparam int MXINT8_SCALE_WIDTH = 8;
  localparam logic [7:0] MXINT8_SCALE_NAN = 8'hFF;

endpackage

// File: rtl/mxint8_block_assembler_if.sv
// Beat-in / block-out handshake bundle of the MXINT8 block assembler.
// slave = assembler side, master = producer/consumer side.
interface mxint8_block_assembler_if #(
  parameter int LANES = 4
);

  logic                                              i_valid;
  logic                                              o_ready;
  logic [mxint8_includes::MXINT8_SCALE_WIDTH-1:0]    i_scale;
  logic [LANES*mxint8_includes::MXINT8_ELEMENT_WIDTH-1:0] i_elements;
  logic                                              i_last;
  logic                                              o_valid;
  logic                                              i_ready;
  logic [mxint8_includes::MXINT8_SCALE_WIDTH-1:0]    o_scale;
  logic [mxint8_includes::BLOCK_SIZE*mxint8_includes::MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements;
  logic                                              o_err;

  modport slave (
    input  i_valid, i_scale, i_elements, i_last, i_ready,
    output o_ready, o_valid, o_scale, o_mxint8_elements, o_err
  );

  modport master (
    output i_valid, i_scale, i_elements, i_last, i_ready,
    input  o_ready, o_valid, o_scale, o_mxint8_elements, o_err
  );

endinterface

// File: rtl/mxint8_block_buffer.sv
// One MXINT8 block register with its EMPTY/FILL/FULL state machine and a
// beat-wide write port. Contents are frozen while FULL.
module mxint8_block_buffer
  import mxint8_includes::*;
  import mxint8_block_assembler_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CW    = 3
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_wr_en,
  input  logic [CW-1:0]                         i_wr_beat,
  input  logic                                  i_wr_commit,
  input  logic                                  i_wr_abort,
  input  logic [MXINT8_SCALE_WIDTH-1:0]         i_scale,
  input  logic [LANES*MXINT8_ELEMENT_WIDTH-1:0] i_elements,
  input  logic                                  i_rd,
  output logic                                  o_full,
  output logic [MXINT8_SCALE_WIDTH-1:0]         o_scale,
  output logic [BLOCK_BITS-1:0]                 o_block
);

  localparam int BEAT_BITS = LANES * MXINT8_ELEMENT_WIDTH;

  buf_state_e                    r_state;
  buf_state_e                    w_state_nxt;
  logic [MXINT8_SCALE_WIDTH-1:0] r_scale;
  logic [BLOCK_BITS-1:0]         r_block;
  logic                          w_write;

  assign w_write = i_wr_en && (r_state != BUF_FULL);
  assign o_scale = r_scale;
  assign o_block = r_block;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a framing error drops the partial block
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUF_EMPTY: begin
        if (i_wr_en && !i_wr_abort) begin
          w_state_nxt = i_wr_commit ? BUF_FULL : BUF_FILL;
        end else begin
          w_state_nxt = BUF_EMPTY;
        end
      end
      BUF_FILL: begin
        if (i_wr_en && i_wr_abort) begin
          w_state_nxt = BUF_EMPTY;
        end else if (i_wr_en && i_wr_commit) begin
          w_state_nxt = BUF_FULL;
        end else begin
          w_state_nxt = BUF_FILL;
        end
      end
      BUF_FULL: begin
        if (i_rd) begin
          w_state_nxt = BUF_EMPTY;
        end else begin
          w_state_nxt = BUF_FULL;
        end
      end
      default: w_state_nxt = BUF_EMPTY;
    endcase
  end

  // Output decode
  always_comb begin
    o_full = 1'b0;
    if (r_state == BUF_FULL) begin
      o_full = 1'b1;
    end else begin
      o_full = 1'b0;
    end
  end

  // Beat write; the scale is captured from beat 0 only
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scale <= '0;
      r_block <= '0;
    end else if (w_write) begin
      r_block[int'(i_wr_beat)*BEAT_BITS +: BEAT_BITS] <= i_elements;
      if (i_wr_beat == {CW{1'b0}}) begin
        r_scale <= i_scale;
      end
    end
  end

endmodule

// File: rtl/mxint8_block_assembler.sv
// Collects LANES-wide int8 beats into a BLOCK_SIZE MXINT8 block plus scale.
// Define MXINT8_ASSEMBLER_PINGPONG_EN for two buffers and full-rate streaming.
module mxint8_block_assembler
  import mxint8_includes::*;
  import mxint8_block_assembler_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  mxint8_block_assembler_if.slave bus
);

  localparam int BEATS = BLOCK_SIZE / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0] r_beat_cnt;
  logic          r_err;
  logic          w_beat;
  logic          w_xfer;
  logic          w_frame_err;
  logic          w_commit;

  assign w_beat      = bus.i_valid && bus.o_ready;
  assign w_xfer      = bus.o_valid && bus.i_ready;
  assign w_frame_err = w_beat && frame_error(bus.i_last, r_beat_cnt == LAST_BEAT);
  assign w_commit    = w_beat && bus.i_last && (r_beat_cnt == LAST_BEAT);
  assign bus.o_err   = r_err;

  // Beat counter: wraps after the final beat and restarts on a framing error
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat_cnt <= '0;
    end else if (w_frame_err || w_commit) begin
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  // Error pulse, one cycle after the offending beat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_frame_err;
    end
  end

`ifdef MXINT8_ASSEMBLER_PINGPONG_EN
  logic                          r_wr_ptr;
  logic                          r_rd_ptr;
  logic [1:0]                    w_full;
  logic [MXINT8_SCALE_WIDTH-1:0] w_scale [2];
  logic [BLOCK_BITS-1:0]         w_block [2];

  for (genvar g = 0; g < 2; g++) begin : g_buf
    mxint8_block_buffer #(.LANES(LANES), .CW(CW)) u_buf (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr_en     (w_beat && (r_wr_ptr == 1'(g))),
      .i_wr_beat   (r_beat_cnt),
      .i_wr_commit (w_commit),
      .i_wr_abort  (w_frame_err),
      .i_scale     (bus.i_scale),
      .i_elements  (bus.i_elements),
      .i_rd        (w_xfer && (r_rd_ptr == 1'(g))),
      .o_full      (w_full[g]),
      .o_scale     (w_scale[g]),
      .o_block     (w_block[g])
    );
  end

  // Pointers advance on block completion / transfer, preserving arrival order
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  assign bus.o_ready           = ~(w_full[0] & w_full[1]);
  assign bus.o_valid           = w_full[r_rd_ptr];
  assign bus.o_scale           = w_scale[r_rd_ptr];
  assign bus.o_mxint8_elements = w_block[r_rd_ptr];
`else
  logic w_full;

  mxint8_block_buffer #(.LANES(LANES), .CW(CW)) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (w_beat),
    .i_wr_beat   (r_beat_cnt),
    .i_wr_commit (w_commit),
    .i_wr_abort  (w_frame_err),
    .i_scale     (bus.i_scale),
    .i_elements  (bus.i_elements),
    .i_rd        (w_xfer),
    .o_full      (w_full),
    .o_scale     (bus.o_scale),
    .o_block     (bus.o_mxint8_elements)
  );

  assign bus.o_ready = ~w_full;
  assign bus.o_valid = w_full;
`endif

endmodule

// File: doc/mxint8_block_assembler.md
MXINT8_BLOCK_ASSEMBLER -- requirements
Module: mxint8_block_assembler

Interface
REQ-001 SHALL have parameter LANES, default 4, elements accepted per input beat; BLOCK_SIZE % LANES == 0.
REQ-002 SHALL take BLOCK_SIZE (32) and MXINT8_ELEMENT_WIDTH (8) from the shared constants, not as local parameters.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  clock, all state on rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_valid  input  1  input beat valid.
REQ-007 o_ready  output  1  assembler can accept a beat.
REQ-008 i_scale  input  8  E8M0 shared scale; sampled on the first beat of a block only.
REQ-009 i_elements  input  LANES x 8  int8 elements; lane 0 is the lowest element index.
REQ-010 i_last  input  1  producer marks the final beat of a block.
REQ-011 o_valid  output  1  a complete block is presented.
REQ-012 i_ready  input  1  downstream (negate/ALU stage) accepts the block.
REQ-013 o_scale  output  8  scale of the presented block.
REQ-014 o_mxint8_elements  output  BLOCK_SIZE x 8  assembled elements.
REQ-015 o_err  output  1  one-cycle pulse on block-framing error.

Function
REQ-016 Beat transfer SHALL occur when i_valid && o_ready; block transfer SHALL occur when o_valid && i_ready.
REQ-017 Beat k of a block (k = 0..BEATS-1, BEATS = BLOCK_SIZE/LANES) SHALL write elements [k*LANES +: LANES].
REQ-018 A beat counter SHALL increment per beat and wrap to 0 after beat BEATS-1.
REQ-019 Buffer FSM states SHALL be EMPTY, FILL and FULL: EMPTY->FILL on the first beat, FILL->FULL on beat BEATS-1, FULL->EMPTY on block transfer.
REQ-020 o_valid SHALL be asserted exactly in FULL; o_scale and o_mxint8_elements SHALL be stable while o_valid && !i_ready.
REQ-021 Latency SHALL be one cycle: o_valid rises in the cycle after the final beat transfer.
REQ-022 o_ready SHALL be a function of registered state only, with no combinational path from i_ready or i_valid.
REQ-023 Framing error is i_last==1 on a beat k != BEATS-1, or i_last==0 on beat BEATS-1.
REQ-024 On a framing error, o_err SHALL pulse the next cycle, the partial block SHALL be discarded, and the counter SHALL return to 0.
REQ-025 On a framing error at k == BEATS-1, the block SHALL NOT be presented.
REQ-026 Element and scale values SHALL pass bit-exact, with no arithmetic.
REQ-027 Scale 0xFF (NaN) SHALL be passed unmodified.

Reset
REQ-028 Reset SHALL force: FSM(s) to EMPTY, counter 0, o_valid 0, o_err 0, o_ready 1, o_scale 0, and all elements 0.
REQ-029 Reset mid-block or mid-hold SHALL discard all data with no block emitted.

Configuration
REQ-030 Without MXINT8_ASSEMBLER_PINGPONG_EN: one buffer, and o_ready = (state != FULL), giving a one-cycle bubble per block minimum.
REQ-031 With MXINT8_ASSEMBLER_PINGPONG_EN: two buffers with write/read pointers.
REQ-032 In ping-pong mode, o_ready SHALL deassert only when both buffers are FULL.
REQ-033 In ping-pong mode, blocks SHALL be presented in arrival order.
REQ-034 In ping-pong mode, a final beat and a block transfer in the same cycle SHALL both take effect.
REQ-035 In ping-pong mode, sustained throughput SHALL be one beat per cycle with i_ready held high.

Structure
REQ-036 MXINT8_ELEMENT_WIDTH, BLOCK_SIZE, MXINT8_SCALE_WIDTH (8) and MXINT8_SCALE_NAN (8'hFF) SHALL reside in the shared mxint8_includes constants.
REQ-037 One sub-module SHALL exist: mxint8_block_buffer (one block register, FSM, write port); ping-pong mode instantiates two.

Verification
REQ-038 Reset, then 8 beats with elements 0..31 and scale 0x7F, i_ready=1 -> o_valid 1 cycle after beat 8, element[i]=i, o_scale=0x7F.
REQ-039 Hold i_ready=0 for 5 cycles with a FULL buffer -> outputs stable, o_ready=0 (single-buffer build), no beat lost.
REQ-040 i_last on beat 3 -> o_err pulses once, no o_valid; the next clean 8-beat block is assembled correctly.
REQ-041 Ping-pong build, back-to-back 4 blocks, i_valid and i_ready held 1 -> 32 consecutive beats accepted, 4 blocks output in order.
REQ-042 Assert i_rst at beat 5, then send a full block -> only the post-reset block appears, scale taken from its own first beat.
REQ-043 Scale 0xFF, elements 0x80 -> passed bit-exact.
